// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between an instruction
// fetch requester (read-only) and a data requester (read/write), with timeout.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_write_val,
  input  logic [DATA_WIDTH-1:0] mem_read_val,
  input  logic                  mem_response
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            last_d;   // 1 when the most recent grant went to port D
  logic            gnt_d;    // port owning the current transaction
  logic [CW-1:0]   cnt;
  logic            grant_d;
  logic            timeout_hit;
  logic [DATA_WIDTH-1:0] capture_val;

  always_comb begin
    state_next  = state;
    grant_d     = d_req & (~i_req | ~last_d);
    timeout_hit = (cnt == CW'(TIMEOUT - 1));
    capture_val = mem_write_en ? '0 : mem_read_val;
    case (state)
      IDLE:    if (i_req || d_req) state_next = BUSY;
      BUSY:    if (mem_response || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Datapath and registered outputs; ack/err default low so they pulse once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d        <= 1'b0;
      gnt_d         <= 1'b0;
      cnt           <= '0;
      i_rdata       <= '0;
      i_ack         <= 1'b0;
      i_err         <= 1'b0;
      d_rdata       <= '0;
      d_ack         <= 1'b0;
      d_err         <= 1'b0;
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
    end else begin
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d  <= grant_d;
            last_d <= grant_d;
            cnt    <= '0;
            if (grant_d) begin
              mem_addr      <= d_addr;
              mem_write_val <= d_wdata;
              mem_read_en   <= ~d_we;
              mem_write_en  <= d_we;
            end else begin
              mem_addr      <= i_addr;
              mem_write_val <= '0;
              mem_read_en   <= 1'b1;
              mem_write_en  <= 1'b0;
            end
          end
        end
        BUSY: begin
          // A response on the timeout edge takes priority over the abort.
          if (mem_response || timeout_hit) begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            if (gnt_d) begin
              d_ack   <= 1'b1;
              d_err   <= ~mem_response;
              d_rdata <= mem_response ? capture_val : '0;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= ~mem_response;
              i_rdata <= mem_response ? capture_val : '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: completions are predicted into a queue
// when requests are driven and checked when the DUT acks.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = DW + 2;  // {is_d, err, rdata}

  logic          clk;
  logic          reset_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [DW-1:0] mem_write_val;
  logic [DW-1:0] mem_read_val;
  logic          mem_response;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
    .mem_response(mem_response)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_done(input logic is_d, input logic err, input logic [DW-1:0] data);
    exp_q.push_back({is_d, err, data});
  endtask

  // Scoreboard: every ack pops one prediction
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n && (i_ack || d_ack)) begin
      check("single_ack", {30'd0, i_ack & d_ack}, 64'd0);
      if (exp_q.size() == 0) begin
        check("ack_without_expect", {62'd0, i_ack, d_ack}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_port", {63'd0, d_ack}, {63'd0, e[W-1]});
        check("ack_err", {63'd0, d_ack ? d_err : i_err}, {63'd0, e[W-2]});
        check("ack_rdata", {32'd0, d_ack ? d_rdata : i_rdata}, {32'd0, e[DW-1:0]});
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_read_val = '0; mem_response = 0;
    #1 reset_n = 1'b0;
    tick();
    check("rst_read_en", {63'd0, mem_read_en}, 64'd0);
    check("rst_write_en", {63'd0, mem_write_en}, 64'd0);
    check("rst_acks", {62'd0, i_ack, d_ack}, 64'd0);
    check("rst_addr", {32'd0, mem_addr}, 64'd0);
    tick();
    reset_n = 1'b1;

    // Single I read, response 3 cycles after enable
    i_req = 1; i_addr = 32'h10;
    expect_done(1'b0, 1'b0, 32'hA5A5A5A5);
    tick();
    for (int c = 0; c < 3; c++) begin
      check("i_rd_read_en", {63'd0, mem_read_en}, 64'd1);
      check("i_rd_addr", {32'd0, mem_addr}, 64'h10);
      check("i_rd_write_en", {63'd0, mem_write_en}, 64'd0);
      if (c == 2) begin mem_response = 1; mem_read_val = 32'hA5A5A5A5; end
      else tick();
    end
    tick();
    mem_response = 0; i_req = 0;
    check("i_rd_done_read_en", {63'd0, mem_read_en}, 64'd0);
    check("i_rd_done_ack", {63'd0, i_ack}, 64'd1);
    tick();
    check("i_rd_ack_pulse", {63'd0, i_ack}, 64'd0);

    // D write: read data must not leak into d_rdata
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    expect_done(1'b1, 1'b0, 32'h0);
    tick();
    for (int c = 0; c < 2; c++) begin
      check("d_wr_write_en", {63'd0, mem_write_en}, 64'd1);
      check("d_wr_val", {32'd0, mem_write_val}, 64'h12345678);
      check("d_wr_addr", {32'd0, mem_addr}, 64'h20);
      check("d_wr_read_en", {63'd0, mem_read_en}, 64'd0);
      if (c == 1) begin mem_response = 1; mem_read_val = 32'hDEADBEEF; end
      else tick();
    end
    tick();
    mem_response = 0; d_req = 0; d_we = 0;
    check("d_wr_done_write_en", {63'd0, mem_write_en}, 64'd0);
    tick();

    // Contention from reset: D wins first tie, then alternate
    reset_n = 0;
    i_req = 1; i_addr = 32'h1000;
    d_req = 1; d_addr = 32'h2000; d_we = 0;
    tick();
    tick();
    reset_n = 1;
    for (int t = 0; t < 4; t++) begin
      expect_done(t % 2 == 0, 1'b0, 32'h100 + t);
      tick();
      check("cont_addr", {32'd0, mem_addr}, (t % 2 == 0) ? 64'h2000 : 64'h1000);
      check("cont_read_en", {63'd0, mem_read_en}, 64'd1);
      mem_response = 1; mem_read_val = 32'h100 + t;
      tick();
      mem_response = 0;
      if (t == 3) begin i_req = 0; d_req = 0; end
      tick();
    end

    // Timeout on a D read, then a late response that must be ignored
    d_req = 1; d_we = 0; d_addr = 32'h30;
    expect_done(1'b1, 1'b1, 32'h0);
    tick();
    check("to_read_en", {63'd0, mem_read_en}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("to_no_early_ack", {63'd0, d_ack}, 64'd0);
    end
    tick();
    check("to_ack", {63'd0, d_ack}, 64'd1);
    d_req = 0;
    mem_response = 1; mem_read_val = 32'hBAD0BAD0;
    tick();
    mem_response = 0;
    check("to_late_ignored", {32'd0, d_rdata}, 64'd0);
    check("to_late_no_ack", {62'd0, i_ack, d_ack}, 64'd0);
    check("to_late_idle", {63'd0, mem_read_en}, 64'd0);

    d_req = 1; d_addr = 32'h34;
    expect_done(1'b1, 1'b0, 32'h77);
    tick();
    check("after_to_addr", {32'd0, mem_addr}, 64'h34);
    mem_response = 1; mem_read_val = 32'h77;
    tick();
    mem_response = 0; d_req = 0;
    tick();

    // Response on the timeout edge wins
    i_req = 1; i_addr = 32'h40;
    expect_done(1'b0, 1'b0, 32'h5);
    tick();
    tick();
    tick();
    tick();
    mem_response = 1; mem_read_val = 32'h5;
    tick();
    mem_response = 0; i_req = 0;
    check("edge_ack", {63'd0, i_ack}, 64'd1);
    tick();

    // Reset during BUSY drops the transaction, then I gets a fresh grant
    d_req = 1; d_we = 0; d_addr = 32'h50;
    tick();
    tick();
    check("mid_busy_read_en", {63'd0, mem_read_en}, 64'd1);
    reset_n = 0; d_req = 0; i_req = 1; i_addr = 32'h60;
    #1;
    check("mid_rst_enables", {62'd0, mem_read_en, mem_write_en}, 64'd0);
    check("mid_rst_acks", {62'd0, i_ack, d_ack}, 64'd0);
    tick();
    reset_n = 1;
    expect_done(1'b0, 1'b0, 32'h99);
    tick();
    check("post_rst_addr", {32'd0, mem_addr}, 64'h60);
    check("post_rst_read_en", {63'd0, mem_read_en}, 64'd1);
    mem_response = 1; mem_read_val = 32'h99;
    tick();
    mem_response = 0; i_req = 0;
    tick();
    tick();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
